// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues word-aligned fetches over ready/valid, buffers
// returned words in order, presents them to decode, and squashes on EX redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target
);
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]    alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [CW:0]      occupancy;
  logic             accept, rsp_live, rsp_drop, rsp_fill, pop;
  logic             unused_tgt;

  assign unused_tgt = ^ex_target[1:0];

  // Slots held by in-flight wrong-path requests still count against capacity.
  assign occupancy = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
  assign imem_req  = reset && !ex_redirect && (occupancy < DEPTH_C);
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  // A response with nothing outstanding is ignored entirely.
  assign rsp_live  = imem_rvalid && ((pend_cnt_q != '0) || (drop_cnt_q != '0));
  assign rsp_drop  = rsp_live && (drop_cnt_q != '0);
  assign rsp_fill  = rsp_live && (drop_cnt_q == '0) && !ex_redirect;

  assign id_valid  = filled_q[head_q];
  assign pop       = id_valid && id_ready && !ex_redirect;
  assign id_pc     = id_valid ? pc_q[head_q] : 32'h0;
  assign id_instr  = id_valid ? instr_q[head_q] : NOP;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    alloc_cnt_d = alloc_cnt_q;
    pend_cnt_d  = pend_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    filled_d    = filled_q;
    if (ex_redirect) begin
      fetch_pc_d  = {ex_target[31:2], 2'b00};
      head_d      = tail_q;
      fill_d      = tail_q;
      filled_d    = '0;
      alloc_cnt_d = '0;
      pend_cnt_d  = '0;
      drop_cnt_d  = pend_cnt_q + drop_cnt_q - CW'(rsp_live);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tail_d     = tail_q + PW'(1);
      end
      if (pop) begin
        head_d           = head_q + PW'(1);
        filled_d[head_q] = 1'b0;
      end
      // Responses return in order, so the oldest unfilled entry is simply fill_q.
      if (rsp_fill) begin
        fill_d           = fill_q + PW'(1);
        filled_d[fill_q] = 1'b1;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      alloc_cnt_d = alloc_cnt_q + CW'(accept) - CW'(pop);
      pend_cnt_d  = pend_cnt_q + CW'(accept) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q  <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      alloc_cnt_q <= '0;
      pend_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      filled_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      alloc_cnt_q <= alloc_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      filled_q    <= filled_d;
    end
  end

  // Payload storage needs no reset: it is only visible through filled_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q[tail_q] <= fetch_pc_q;
    end
    if (rsp_fill) begin
      instr_q[fill_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order, variable-latency memory model.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;
  logic        ex_redirect;
  logic [31:0] ex_target;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_ready    (id_ready),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mq[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          pop_cnt = 0;
  int          req_cnt = 0;
  logic        rand_ready = 1'b0;
  logic        fix_ready = 1'b1;
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_pc;
  logic [31:0] obs_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hABCD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample, then advance.
  task automatic tick(input logic rdy, input logic redir = 1'b0, input logic [31:0] tgt = 32'h0);
    logic [31:0] e;
    id_ready    = rdy;
    ex_redirect = redir;
    ex_target   = tgt;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end
    imem_ready = rand_ready ? 1'($urandom_range(0, 1)) : fix_ready;
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = id_valid;
    obs_pc    = id_pc;
    obs_instr = id_instr;
    if (imem_req && imem_ready) begin
      mq.push_back('{addr: imem_addr, due: cyc + lat});
      req_cnt++;
    end
    if (id_valid && rdy && !redir) begin
      pop_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("pop_pc", id_pc, e);
      chk("pop_instr", id_instr, instr_of(e));
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, NOP);
    mq.delete();
    exp_q.delete();
    pop_cnt     = 0;
    req_cnt     = 0;
    ex_redirect = 1'b0;
    ex_target   = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_ready  = 1'b0;
    id_ready    = 1'b0;
    rand_ready  = 1'b0;
    fix_ready   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    reset       = 1'b1;
    ex_redirect = 1'b0;
    ex_target   = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_ready  = 1'b0;
    id_ready    = 1'b0;
    @(negedge clk);

    // Streaming from reset, single-cycle memory
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    tick(1'b1);
    chk("t1_first_req", 32'(obs_req), 32'd1);
    chk("t1_first_addr", obs_addr, 32'h0);
    tick(1'b1);
    chk("t1_c1_valid", 32'(obs_valid), 32'd0);
    chk("t1_c1_addr", obs_addr, 32'h4);
    tick(1'b1);
    chk("t1_c2_valid", 32'(obs_valid), 32'd1);
    repeat (5) tick(1'b1);
    chk("t1_pops", pop_cnt, 32'd6);
    chk("t1_exp_left", exp_q.size(), 32'd0);

    // Decode stall for 10 cycles, then release
    do_reset();
    lat = 1;
    repeat (4) tick(1'b0);
    chk("t2_hold_pc", obs_pc, 32'h0);
    chk("t2_hold_instr", obs_instr, instr_of(32'h0));
    repeat (6) tick(1'b0);
    chk("t2_req_cnt", req_cnt, 32'd4);
    chk("t2_req_off", 32'(obs_req), 32'd0);
    chk("t2_hold_valid", 32'(obs_valid), 32'd1);
    chk("t2_hold_pc2", obs_pc, 32'h0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
    repeat (4) tick(1'b1);
    chk("t2_pops", pop_cnt, 32'd4);
    chk("t2_exp_left", exp_q.size(), 32'd0);

    // Redirect with one filled entry and two responses in flight
    do_reset();
    lat = 3;
    fix_ready = 1'b1;
    tick(1'b0);
    fix_ready = 1'b0;
    tick(1'b0);
    fix_ready = 1'b1;
    tick(1'b0);
    tick(1'b0);
    chk("t3_pre_req_cnt", req_cnt, 32'd3);
    tick(1'b0, 1'b1, 32'h0000_0100);
    chk("t3_redir_req", 32'(obs_req), 32'd0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    tick(1'b1);
    chk("t3_target_req", 32'(obs_req), 32'd1);
    chk("t3_target_addr", obs_addr, 32'h100);
    chk("t3_squash_valid", 32'(obs_valid), 32'd0);
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    chk("t3_c8_valid", 32'(obs_valid), 32'd0);
    repeat (3) tick(1'b1);
    chk("t3_pops", pop_cnt, 32'd3);
    chk("t3_exp_left", exp_q.size(), 32'd0);

    // Redirect coincides with a response and a ready decode stage
    do_reset();
    lat = 1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    repeat (3) tick(1'b1);
    tick(1'b1, 1'b1, 32'h0000_0203);
    chk("t4_redir_req", 32'(obs_req), 32'd0);
    tick(1'b1);
    chk("t4_target_addr", obs_addr, 32'h200);
    chk("t4_c4_valid", 32'(obs_valid), 32'd0);
    tick(1'b1);
    chk("t4_c5_valid", 32'(obs_valid), 32'd0);
    repeat (2) tick(1'b1);
    chk("t4_pops", pop_cnt, 32'd3);
    chk("t4_exp_left", exp_q.size(), 32'd0);

    // Fetch address wraps past the top of the address space
    do_reset();
    lat = 1;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    tick(1'b1, 1'b1, 32'hFFFF_FFF8);
    tick(1'b1);
    chk("t5_addr_fff8", obs_addr, 32'hFFFF_FFF8);
    tick(1'b1);
    tick(1'b1);
    chk("t5_addr_wrap", obs_addr, 32'h0);
    repeat (2) tick(1'b1);
    chk("t5_pops", pop_cnt, 32'd3);

    // Random memory acceptance with 3-cycle response latency
    do_reset();
    lat = 3;
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) exp_q.push_back(32'(4 * i));
    repeat (80) tick(1'b1);
    chk("t6_progress", 32'(pop_cnt >= 10), 32'd1);

    // Reset mid-stream, then restart at RESET_PC
    do_reset();
    lat = 1;
    tick(1'b1);
    chk("t7_restart_req", 32'(obs_req), 32'd1);
    chk("t7_restart_addr", obs_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
